// File: rtl/stop_watch_lap_bcd_if.sv
// Button/display bus of the lap stopwatch.
//   btn_pedge   : one-cycle button pulses {recall, clear, lap, start/stop}
//   value       : {sec_tens, sec_ones, csec_tens, csec_ones} BCD
//   min_bcd     : {min_tens, min_ones} BCD
//   running     : stopwatch counting
//   recall_mode : a stored lap is on the display
//   lap_idx     : lap being shown in recall (0 = oldest)
//   lap_count   : valid laps stored, saturating at LAP_DEPTH
//   rollover    : sticky, time wrapped past the maximum
// master = button/display side, slave = stopwatch.
interface stop_watch_lap_bcd_if #(
  parameter int LAP_DEPTH = 4
);
  localparam int IDX_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  logic [3:0]       btn_pedge;
  logic [15:0]      value;
  logic [7:0]       min_bcd;
  logic             running;
  logic             recall_mode;
  logic [IDX_W-1:0] lap_idx;
  logic [CNT_W-1:0] lap_count;
  logic             rollover;

  modport master (
    output btn_pedge,
    input  value, min_bcd, running, recall_mode, lap_idx, lap_count, rollover
  );

  modport slave (
    input  btn_pedge,
    output value, min_bcd, running, recall_mode, lap_idx, lap_count, rollover
  );
endinterface

// File: rtl/stop_watch_lap_bcd.sv
// mm:ss.cc BCD stopwatch with a circular lap buffer and lap recall.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of stop_watch_lap_bcd_if (buttons in, display out)
// A prescaler divides clk down to a 10 ms tick while running. One button
// action is taken per cycle, priority clear > start/stop > lap > recall.
// Laps are stored oldest-first in a LAP_DEPTH ring; once full, a new lap
// overwrites the oldest entry. Display registers are loaded with the value
// the time/recall selection will hold after this edge, so they always
// line up with the state register.
module stop_watch_lap_bcd #(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int LAP_DEPTH   = 4,
  parameter int MAX_MIN     = 59
) (
  input logic                 clk,
  input logic                 reset_n,
  stop_watch_lap_bcd_if.slave bus
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 100;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = $clog2(LAP_DEPTH);
  localparam int CNT_W    = $clog2(LAP_DEPTH + 1);

  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LAP_DEPTH);
  localparam logic [3:0]       MAX_MIN_T = 4'(MAX_MIN / 10);
  localparam logic [3:0]       MAX_MIN_O = 4'(MAX_MIN % 10);

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] cs_t;
    logic [3:0] cs_o;
  } bcd_time_t;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RECALL} state_t;

  state_t                     state, state_nxt;
  logic [PW-1:0]              presc;
  logic                       tick;
  bcd_time_t                  live, live_inc, live_nxt;
  logic                       wrap;
  bcd_time_t                  disp, disp_nxt;
  bcd_time_t [LAP_DEPTH-1:0]  lap_mem;
  logic [IDX_W-1:0]           wr_ptr, old_ptr, lap_idx, idx_nxt, rd_ptr;
  logic [CNT_W-1:0]           lap_count;
  logic                       rollover;
  logic                       running, recall_mode;

  logic act_clr, act_ss, act_lap, act_rcl;
  logic do_clr, do_lap, rcl_enter, rcl_step;

  // Single winning action per cycle; the losers are dropped even if the
  // winner turns out to be ignored in the current state.
  assign act_clr = bus.btn_pedge[2];
  assign act_ss  = bus.btn_pedge[0] & ~bus.btn_pedge[2];
  assign act_lap = bus.btn_pedge[1] & ~bus.btn_pedge[0] & ~bus.btn_pedge[2];
  assign act_rcl = bus.btn_pedge[3] & ~|bus.btn_pedge[2:0];

  assign tick      = (state == RUN) && (presc == PRE_LAST);
  assign do_clr    = act_clr && (state != RUN);
  assign do_lap    = act_lap && (state == RUN);
  assign rcl_enter = act_rcl && ((state == IDLE) || (state == PAUSE)) &&
                     (lap_count != '0);
  assign rcl_step  = act_rcl && (state == RECALL);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, PAUSE: begin
        if (act_clr)        state_nxt = IDLE;
        else if (act_ss)    state_nxt = RUN;
        else if (rcl_enter) state_nxt = RECALL;
      end
      RUN: begin
        if (act_ss) state_nxt = PAUSE;
      end
      RECALL: begin
        if (act_clr)     state_nxt = IDLE;
        else if (act_ss) state_nxt = PAUSE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running     = (state == RUN);
    recall_mode = (state == RECALL);
  end

  // ---------------- BCD time increment ----------------
  // Each digit only advances when every lower digit is at its top value,
  // so no nibble ever leaves its decimal range.
  always_comb begin
    live_inc = live;
    wrap     = 1'b0;
    if (live.cs_o != 4'd9) begin
      live_inc.cs_o = live.cs_o + 4'd1;
    end else begin
      live_inc.cs_o = 4'd0;
      if (live.cs_t != 4'd9) begin
        live_inc.cs_t = live.cs_t + 4'd1;
      end else begin
        live_inc.cs_t = 4'd0;
        if (live.sec_o != 4'd9) begin
          live_inc.sec_o = live.sec_o + 4'd1;
        end else begin
          live_inc.sec_o = 4'd0;
          if (live.sec_t != 4'd5) begin
            live_inc.sec_t = live.sec_t + 4'd1;
          end else begin
            live_inc.sec_t = 4'd0;
            if ((live.min_t == MAX_MIN_T) && (live.min_o == MAX_MIN_O)) begin
              live_inc.min_t = 4'd0;
              live_inc.min_o = 4'd0;
              wrap           = 1'b1;
            end else if (live.min_o != 4'd9) begin
              live_inc.min_o = live.min_o + 4'd1;
            end else begin
              live_inc.min_o = 4'd0;
              live_inc.min_t = live.min_t + 4'd1;
            end
          end
        end
      end
    end
  end

  // tick and do_clr never coincide: tick needs RUN, clear is ignored there.
  always_comb begin
    live_nxt = live;
    if (do_clr)    live_nxt = '0;
    else if (tick) live_nxt = live_inc;
  end

  // ---------------- recall index / display select ----------------
  always_comb begin
    idx_nxt = lap_idx;
    if (state_nxt != RECALL) begin
      idx_nxt = '0;
    end else if (rcl_enter) begin
      idx_nxt = '0;
    end else if (rcl_step) begin
      if (CNT_W'(lap_idx) == (lap_count - CNT_W'(1))) idx_nxt = '0;
      else                                           idx_nxt = lap_idx + 1'b1;
    end
  end

  // lap_idx is relative to the oldest entry; the ring wraps naturally
  // because LAP_DEPTH is a power of two.
  assign rd_ptr = old_ptr + idx_nxt;

  always_comb begin
    disp_nxt = live_nxt;
    if (state_nxt == RECALL) disp_nxt = lap_mem[rd_ptr];
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      live      <= '0;
      disp      <= '0;
      lap_idx   <= '0;
      rollover  <= 1'b0;
      wr_ptr    <= '0;
      old_ptr   <= '0;
      lap_count <= '0;
    end else begin
      // Prescaler holds outside RUN so a resume keeps the partial tick.
      if (do_clr)            presc <= '0;
      else if (state == RUN) presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;

      live    <= live_nxt;
      disp    <= disp_nxt;
      lap_idx <= idx_nxt;

      if (do_clr)            rollover <= 1'b0;
      else if (tick && wrap) rollover <= 1'b1;

      if (do_clr) begin
        wr_ptr    <= '0;
        old_ptr   <= '0;
        lap_count <= '0;
      end else if (do_lap) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (lap_count == CNT_FULL) old_ptr   <= old_ptr + 1'b1;
        else                       lap_count <= lap_count + 1'b1;
      end
    end
  end

  // Lap capture takes the registered (pre-tick) time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    lap_mem <= '0;
    else if (do_lap) lap_mem[wr_ptr] <= live;
  end

  // ---------------- outputs ----------------
  assign bus.value       = {disp.sec_t, disp.sec_o, disp.cs_t, disp.cs_o};
  assign bus.min_bcd     = {disp.min_t, disp.min_o};
  assign bus.running     = running;
  assign bus.recall_mode = recall_mode;
  assign bus.lap_idx     = lap_idx;
  assign bus.lap_count   = lap_count;
  assign bus.rollover    = rollover;

endmodule

// File: tb/tb_stop_watch_lap_bcd.sv
// Directed bench for stop_watch_lap_bcd. CLK_FREQ_HZ=400 gives a tick every
// 4 clocks and MAX_MIN=1 puts the wrap at 01:59.99, so the minute carry and
// the rollover both fit in a short run.
module tb_stop_watch_lap_bcd;
  localparam int CLK_FREQ_HZ = 400;
  localparam int LAP_DEPTH   = 4;
  localparam int MAX_MIN     = 1;

  localparam logic [3:0] B_NO  = 4'b0000;
  localparam logic [3:0] B_SS  = 4'b0001;
  localparam logic [3:0] B_LAP = 4'b0010;
  localparam logic [3:0] B_CLR = 4'b0100;
  localparam logic [3:0] B_RCL = 4'b1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stop_watch_lap_bcd_if #(.LAP_DEPTH(LAP_DEPTH)) bus ();

  stop_watch_lap_bcd #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .LAP_DEPTH  (LAP_DEPTH),
    .MAX_MIN    (MAX_MIN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]  btn;
    int          wait_n;
    logic [15:0] value;
    logic [7:0]  min_bcd;
    logic        run;
    logic        rcl;
    logic [1:0]  idx;
    logic [2:0]  cnt;
    logic        roll;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] btn, input int w, input logic [15:0] v,
                     input logic [7:0] m, input logic run, input logic rcl,
                     input logic [1:0] idx, input logic [2:0] cnt, input logic roll);
    vec_t r;
    r.btn = btn; r.wait_n = w; r.value = v; r.min_bcd = m; r.run = run;
    r.rcl = rcl; r.idx = idx; r.cnt = cnt; r.roll = roll;
    vecs.push_back(r);
  endtask

  // Called at a negedge: button is sampled by the next rising edge.
  task automatic pulse(input logic [3:0] b);
    bus.btn_pedge = b;
    @(negedge clk);
    bus.btn_pedge = B_NO;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [15:0] v, input logic [7:0] m,
                           input logic run, input logic rcl, input logic [1:0] idx,
                           input logic [2:0] cnt, input logic roll);
    check({tag, " value"},   32'(bus.value),       32'(v));
    check({tag, " min"},     32'(bus.min_bcd),     32'(m));
    check({tag, " running"}, 32'(bus.running),     32'(run));
    check({tag, " recall"},  32'(bus.recall_mode), 32'(rcl));
    check({tag, " idx"},     32'(bus.lap_idx),     32'(idx));
    check({tag, " count"},   32'(bus.lap_count),   32'(cnt));
    check({tag, " roll"},    32'(bus.rollover),    32'(roll));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Each record: pulse btn for one edge, wait wait_n more edges, compare.
    // Times: tick on every 4th edge after the start edge.
    // -- basic run / pause / resume keeps prescaler fraction
    add(B_SS,    0, 16'h0000, 8'h00, 1, 0, 0, 0, 0);
    add(B_NO,  999, 16'h0250, 8'h00, 1, 0, 0, 0, 0);  // 1000 clk = 250 ticks
    add(B_SS,    0, 16'h0250, 8'h00, 0, 0, 0, 0, 0);
    add(B_NO,  199, 16'h0250, 8'h00, 0, 0, 0, 0, 0);  // frozen
    add(B_SS,    1, 16'h0250, 8'h00, 1, 0, 0, 0, 0);
    add(B_NO,    0, 16'h0250, 8'h00, 1, 0, 0, 0, 0);
    add(B_NO,    0, 16'h0251, 8'h00, 1, 0, 0, 0, 0);  // 3 run edges after resume
    add(B_SS,    0, 16'h0251, 8'h00, 0, 0, 0, 0, 0);
    add(B_CLR,   0, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
    // -- laps at .05, .12, .30 (last one on a tick edge: pre-tick value kept)
    add(B_SS,   20, 16'h0005, 8'h00, 1, 0, 0, 0, 0);
    add(B_LAP,   0, 16'h0005, 8'h00, 1, 0, 0, 1, 0);
    add(B_NO,   26, 16'h0012, 8'h00, 1, 0, 0, 1, 0);
    add(B_LAP,   0, 16'h0012, 8'h00, 1, 0, 0, 2, 0);
    add(B_NO,   73, 16'h0030, 8'h00, 1, 0, 0, 2, 0);
    add(B_LAP,   0, 16'h0031, 8'h00, 1, 0, 0, 3, 0);
    add(B_SS,    0, 16'h0031, 8'h00, 0, 0, 0, 3, 0);
    add(B_RCL,   0, 16'h0005, 8'h00, 0, 1, 0, 3, 0);
    add(B_RCL,   0, 16'h0012, 8'h00, 0, 1, 1, 3, 0);
    add(B_RCL,   0, 16'h0030, 8'h00, 0, 1, 2, 3, 0);
    add(B_LAP,   0, 16'h0030, 8'h00, 0, 1, 2, 3, 0);  // lap ignored in recall
    add(B_RCL,   0, 16'h0005, 8'h00, 0, 1, 0, 3, 0);  // wraps to oldest
    add(B_SS,    0, 16'h0031, 8'h00, 0, 0, 0, 3, 0);  // back to pause, live time
    // -- clear beats stop and lap in pause; recall with no laps ignored
    add(4'b0111, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
    add(B_RCL,   0, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
    // -- six laps into a 4-deep ring: stored 09,19,29,39,49,59
    add(B_SS,   39, 16'h0009, 8'h00, 1, 0, 0, 0, 0);
    add(B_LAP,  39, 16'h0019, 8'h00, 1, 0, 0, 1, 0);
    add(B_LAP,  39, 16'h0029, 8'h00, 1, 0, 0, 2, 0);
    add(B_LAP,  39, 16'h0039, 8'h00, 1, 0, 0, 3, 0);
    add(B_LAP,  39, 16'h0049, 8'h00, 1, 0, 0, 4, 0);
    add(B_LAP,  39, 16'h0059, 8'h00, 1, 0, 0, 4, 0);
    add(B_LAP,  39, 16'h0069, 8'h00, 1, 0, 0, 4, 0);
    add(B_SS,    0, 16'h0070, 8'h00, 0, 0, 0, 4, 0);
    add(B_RCL,   0, 16'h0029, 8'h00, 0, 1, 0, 4, 0);
    add(B_RCL,   0, 16'h0039, 8'h00, 0, 1, 1, 4, 0);
    add(B_RCL,   0, 16'h0049, 8'h00, 0, 1, 2, 4, 0);
    add(B_RCL,   0, 16'h0059, 8'h00, 0, 1, 3, 4, 0);
    add(B_RCL,   0, 16'h0029, 8'h00, 0, 1, 0, 4, 0);
    add(B_SS,    0, 16'h0070, 8'h00, 0, 0, 0, 4, 0);
    // -- stop beats lap in run: oldest entry must still be 29
    add(B_SS,    0, 16'h0070, 8'h00, 1, 0, 0, 4, 0);
    add(4'b0011, 0, 16'h0070, 8'h00, 0, 0, 0, 4, 0);
    add(B_RCL,   0, 16'h0029, 8'h00, 0, 1, 0, 4, 0);
    add(B_CLR,   0, 16'h0000, 8'h00, 0, 0, 0, 0, 0);

    // reset state
    bus.btn_pedge = B_NO;
    reset_n = 1'b0;
    cyc(2);
    check_all("reset", 16'h0000, 8'h00, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    cyc(1);

    foreach (vecs[i]) begin
      pulse(vecs[i].btn);
      cyc(vecs[i].wait_n);
      check_all($sformatf("vec%0d", i), vecs[i].value, vecs[i].min_bcd, vecs[i].run,
                vecs[i].rcl, vecs[i].idx, vecs[i].cnt, vecs[i].roll);
    end

    // -- minute carry, clear ignored in run, wrap at 01:59.99
    pulse(B_SS);
    cyc(23999);
    check_all("t4 0:59.99", 16'h5999, 8'h00, 1, 0, 0, 0, 0);
    cyc(1);
    check_all("t4 1:00.00", 16'h0000, 8'h01, 1, 0, 0, 0, 0);
    cyc(23995);
    check_all("t4 1:59.98", 16'h5998, 8'h01, 1, 0, 0, 0, 0);
    cyc(1);
    check_all("t4 1:59.99", 16'h5999, 8'h01, 1, 0, 0, 0, 0);
    pulse(B_CLR);
    check_all("t4 clr ign", 16'h5999, 8'h01, 1, 0, 0, 0, 0);
    cyc(2);
    check_all("t4 pre-wrap", 16'h5999, 8'h01, 1, 0, 0, 0, 0);
    cyc(1);
    check_all("t4 wrap", 16'h0000, 8'h00, 1, 0, 0, 0, 1);
    cyc(4);
    check_all("t4 sticky", 16'h0001, 8'h00, 1, 0, 0, 0, 1);
    pulse(B_SS);
    pulse(B_CLR);
    check_all("t4 cleared", 16'h0000, 8'h00, 0, 0, 0, 0, 0);

    // -- asynchronous reset mid-run, mid-cycle
    pulse(B_SS);
    cyc(37);
    pulse(B_LAP);
    cyc(5);
    check_all("t6 pre", 16'h0010, 8'h00, 1, 0, 0, 1, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("t6 async", 16'h0000, 8'h00, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2);
    check_all("t6 release", 16'h0000, 8'h00, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
